// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - pixel request / colour return bus between the VGA timing generator and its upstream source
interface vga_timing_gen_if #(
  parameter int CNT_W   = 11,
  parameter int COLOR_W = 10
);
  logic [CNT_W-1:0]   oX;
  logic [CNT_W-1:0]   oY;
  logic               oReq;
  logic               oLineStart;
  logic               oFrameStart;
  logic [15:0]        oFrame;
  logic [COLOR_W-1:0] iRed;
  logic [COLOR_W-1:0] iGreen;
  logic [COLOR_W-1:0] iBlue;

  modport master (
    output oX, oY, oReq, oLineStart, oFrameStart, oFrame,
    input  iRed, iGreen, iBlue
  );

  modport slave (
    input  oX, oY, oReq, oLineStart, oFrameStart, oFrame,
    output iRed, iGreen, iBlue
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator and DAC output stage; VGA_TESTPAT_EN adds an 8-bar colour pattern source
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CNT_W    = 11,
  parameter int COLOR_W  = 10,
  parameter int PIPE_LAT = 2
) (
  input  logic               CLK_25,
  input  logic               nRst,
`ifdef VGA_TESTPAT_EN
  input  logic               iPatEn,
`endif
  output logic               VGA_CLK,
  output logic               VGA_SYNC,
  output logic               VGA_BLANK,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B,
  vga_timing_gen_if.master   pix
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  // Idle (inactive) pin level of each sync; XOR with the active-high raw sync gives the pin value.
  localparam logic HS_OFF = (HS_POL == 0);
  localparam logic VS_OFF = (VS_POL == 0);

  logic [CNT_W-1:0]   hcnt;
  logic [CNT_W-1:0]   vcnt;
  logic [15:0]        frame_cnt;
  logic               h_wrap;
  logic               v_wrap;
  logic               act_raw;
  logic               hs_raw;
  logic               vs_raw;
  logic [PIPE_LAT-1:0] act_dl;
  logic [PIPE_LAT-1:0] hs_dl;
  logic [PIPE_LAT-1:0] vs_dl;
  logic               act_d;
  logic               hs_d;
  logic               vs_d;
  logic [COLOR_W-1:0] red_src;
  logic [COLOR_W-1:0] green_src;
  logic [COLOR_W-1:0] blue_src;

  assign h_wrap = (hcnt == H_LAST);
  assign v_wrap = (vcnt == V_LAST);

  // Raster counters: hcnt every clock, vcnt on line wrap, frame count on full-frame wrap
  always_ff @(posedge CLK_25) begin
    if (!nRst) begin
      hcnt      <= '0;
      vcnt      <= '0;
      frame_cnt <= '0;
    end else if (h_wrap) begin
      hcnt <= '0;
      if (v_wrap) begin
        vcnt      <= '0;
        frame_cnt <= frame_cnt + 16'd1;
      end else begin
        vcnt <= vcnt + CNT_W'(1);
      end
    end else begin
      hcnt <= hcnt + CNT_W'(1);
    end
  end

  // Stage-0 decode straight from the counters
  assign act_raw = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign hs_raw  = (hcnt >= HS_BEG) && (hcnt < HS_END);
  assign vs_raw  = (vcnt >= VS_BEG) && (vcnt < VS_END);

  assign pix.oX          = hcnt;
  assign pix.oY          = vcnt;
  assign pix.oReq        = act_raw;
  assign pix.oLineStart  = (hcnt == '0) && (vcnt < V_ACT);
  assign pix.oFrameStart = (hcnt == '0) && (vcnt == '0);
  assign pix.oFrame      = frame_cnt;

  // Delay line so sync and blank line up with colour returned PIPE_LAT clocks after the request
  always_ff @(posedge CLK_25) begin
    if (!nRst) begin
      act_dl <= '0;
      hs_dl  <= '0;
      vs_dl  <= '0;
    end else begin
      act_dl[0] <= act_raw;
      hs_dl[0]  <= hs_raw;
      vs_dl[0]  <= vs_raw;
      for (int i = 1; i < PIPE_LAT; i++) begin
        act_dl[i] <= act_dl[i-1];
        hs_dl[i]  <= hs_dl[i-1];
        vs_dl[i]  <= vs_dl[i-1];
      end
    end
  end

  assign act_d = act_dl[PIPE_LAT-1];
  assign hs_d  = hs_dl[PIPE_LAT-1];
  assign vs_d  = vs_dl[PIPE_LAT-1];

`ifdef VGA_TESTPAT_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic [CNT_W-1:0] x_dl [PIPE_LAT];
  logic [2:0]       bar;

  // Delayed x coordinate so the pattern bar matches the pixel at the output tap
  always_ff @(posedge CLK_25) begin
    if (!nRst) begin
      for (int i = 0; i < PIPE_LAT; i++) x_dl[i] <= '0;
    end else begin
      x_dl[0] <= hcnt;
      for (int i = 1; i < PIPE_LAT; i++) x_dl[i] <= x_dl[i-1];
    end
  end

  // Bar index 0..7 = white, yellow, cyan, green, magenta, red, blue, black:
  // green is on for bars 0-3, red skips bit 1, blue is on for even bars.
  assign bar = 3'(x_dl[PIPE_LAT-1] / CNT_W'(BAR_W));

  // Colour source select: internal pattern or upstream data
  always_comb begin
    red_src   = pix.iRed;
    green_src = pix.iGreen;
    blue_src  = pix.iBlue;
    if (iPatEn) begin
      red_src   = {COLOR_W{~bar[1]}};
      green_src = {COLOR_W{~bar[2]}};
      blue_src  = {COLOR_W{~bar[0]}};
    end
  end
`else
  assign red_src   = pix.iRed;
  assign green_src = pix.iGreen;
  assign blue_src  = pix.iBlue;
`endif

  // Final pin registers: sync, blank and colour all leave on the same edge
  always_ff @(posedge CLK_25) begin
    if (!nRst) begin
      VGA_HS    <= HS_OFF;
      VGA_VS    <= VS_OFF;
      VGA_BLANK <= 1'b0;
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
    end else begin
      VGA_HS    <= hs_d ^ HS_OFF;
      VGA_VS    <= vs_d ^ VS_OFF;
      VGA_BLANK <= act_d;
      VGA_R     <= act_d ? red_src   : '0;
      VGA_G     <= act_d ? green_src : '0;
      VGA_B     <= act_d ? blue_src  : '0;
    end
  end

  assign VGA_CLK  = CLK_25;
  assign VGA_SYNC = 1'b1;

endmodule
